// File: rtl/pixel_sensor_controller.sv
// pixel_sensor_controller: frame sequencer driving erase, exposure, single-slope conversion and row readout
package PixelSensorConfig;
  localparam int PIXEL_ARRAY_HEIGHT = 2;
endpackage

module pixel_sensor_controller #(
  parameter int PIXEL_ARRAY_HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
  parameter int ERASE_CYCLES = 5,
  parameter int EXPOSE_CYCLES = 255,
  parameter int READ_CYCLES = 2,
  localparam int RW = PIXEL_ARRAY_HEIGHT > 1 ? $clog2(PIXEL_ARRAY_HEIGHT) : 1
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          START,
  output logic                          ERASE,
  output logic                          EXPOSE,
  output logic                          ANALOG_RAMP,
  output logic [7:0]                    DIGITAL_RAMP,
  output logic [PIXEL_ARRAY_HEIGHT-1:0] READ,
  output logic [RW-1:0]                 ROW_INDEX,
  output logic                          ROW_VALID,
  output logic                          BUSY,
  output logic                          FRAME_DONE
);
  localparam int M1 = ERASE_CYCLES > EXPOSE_CYCLES ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int M2 = M1 > READ_CYCLES ? M1 : READ_CYCLES;
  localparam int CW = $clog2(M2 > 256 ? M2 : 256);
  typedef enum logic [2:0] {IDLE, ERASE_S, EXPOSE_S, CONVERT_S, READ_S} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [RW-1:0] row, row_nx;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt - 1'b1;
    row_nx = row;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        row_nx = '0;
        if (START) begin
          state_nx = ERASE_S;
          cnt_nx = CW'(ERASE_CYCLES - 1);
        end
      end
      ERASE_S: if (cnt == '0) begin
        state_nx = EXPOSE_S;
        cnt_nx = CW'(EXPOSE_CYCLES - 1);
      end
      EXPOSE_S: if (cnt == '0) begin
        state_nx = CONVERT_S;
        cnt_nx = CW'(255);
      end
      CONVERT_S: if (cnt == '0) begin
        state_nx = READ_S;
        cnt_nx = CW'(READ_CYCLES - 1);
        row_nx = '0;
      end
      READ_S: if (cnt == '0) begin
        if (row == RW'(PIXEL_ARRAY_HEIGHT - 1)) begin
          state_nx = IDLE;
          cnt_nx = '0;
          row_nx = '0;
        end else begin
          row_nx = row + 1'b1;
          cnt_nx = CW'(READ_CYCLES - 1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx = '0;
        row_nx = '0;
      end
    endcase
  end
  // outputs are registered from the next-state view so each phase output aligns with its state
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      cnt <= '0;
      row <= '0;
      ERASE <= 1'b0;
      EXPOSE <= 1'b0;
      ANALOG_RAMP <= 1'b0;
      DIGITAL_RAMP <= '0;
      READ <= '0;
      ROW_INDEX <= '0;
      ROW_VALID <= 1'b0;
      BUSY <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      row <= row_nx;
      ERASE <= state_nx == ERASE_S;
      EXPOSE <= state_nx == EXPOSE_S;
      ANALOG_RAMP <= state_nx == CONVERT_S;
      DIGITAL_RAMP <= state_nx == CONVERT_S ? 8'(CW'(255) - cnt_nx) : '0;
      READ <= state_nx == READ_S ? PIXEL_ARRAY_HEIGHT'(1) << row_nx : '0;
      ROW_INDEX <= state_nx == READ_S ? row_nx : '0;
      ROW_VALID <= state_nx == READ_S && cnt_nx == '0;
      BUSY <= state_nx != IDLE;
      FRAME_DONE <= state == READ_S && state_nx == IDLE;
    end
endmodule
